// File: rtl/iob_eth_mii_frame_gen.sv
// -----------------------------------------------------------------------------
// iob_eth_mii_frame_gen
//
// Generates one complete Ethernet frame on a 4-bit MII-style interface per
// start request: 15 preamble nibbles, SFD, 14-byte header, payload fetched
// byte by byte through a data_ready/data_valid handshake, zero padding up to
// MIN_PAYLOAD bytes, the 32-bit FCS, then an inter-frame gap.
//
// Ports
//   clk        : MII clock, all logic on the rising edge
//   rst_int    : asynchronous active-high reset
//   start      : single-cycle frame request, honoured only while busy=0
//   dst_mac    : destination MAC, [47:40] first on the wire
//   src_mac    : source MAC, [47:40] first on the wire
//   eth_type   : EtherType/length, [15:8] first on the wire
//   nbytes     : payload byte count (0..2047)
//   data_in    : payload byte, sampled in a data_ready cycle
//   data_valid : data_in is valid
//   data_ready : payload byte is sampled this cycle
//   busy       : frame or inter-frame gap in progress
//   done       : one-cycle pulse in the last gap cycle
//   underrun   : one-cycle pulse when a frame is aborted for lack of data
//   mii_dv     : MII data valid
//   mii_data   : MII nibble, low nibble of each byte first
// -----------------------------------------------------------------------------
module iob_eth_mii_frame_gen #(
    parameter int IFG_NIBBLES = 24,
    parameter int MIN_PAYLOAD = 46
) (
    input  logic        clk,
    input  logic        rst_int,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] eth_type,
    input  logic [10:0] nbytes,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        mii_dv,
    output logic [3:0]  mii_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_HDR  = 3'd3,
        ST_PAY  = 3'd4,
        ST_PAD  = 3'd5,
        ST_FCS  = 3'd6,
        ST_IFG  = 3'd7
    } state_t;

    localparam logic [11:0] IFG_LAST  = 12'(IFG_NIBBLES - 1);
    localparam logic [10:0] MIN_BYTES = 11'(MIN_PAYLOAD);
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    // Reflected CRC-32 advanced by one nibble (nibble bit 0 enters first).
    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc ^ {28'd0, nib};
        for (int i = 0; i < 4; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [11:0] cnt_r, cnt_nxt_s;
    logic [47:0] dst_r, src_r;
    logic [15:0] type_r;
    logic [10:0] nbytes_r;
    logic [3:0]  byte_hi_r;
    logic [31:0] crc_r, crc_nxt_s;

    logic        mii_dv_r, busy_r, done_r, underrun_r, data_ready_r;
    logic [3:0]  mii_data_r;

    logic        mii_dv_nxt_s, busy_nxt_s, done_nxt_s, underrun_nxt_s, ready_nxt_s;
    logic [3:0]  mii_data_nxt_s;
    logic        latch_s;
    logic [11:0] pay_last_s, pad_last_s;
    logic [7:0]  hdr_byte_s;
    logic [3:0]  fcs_nib_s;

    assign mii_dv     = mii_dv_r;
    assign mii_data   = mii_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign underrun   = underrun_r;
    assign data_ready = data_ready_r;

    // Last nibble index of the payload and of the padding (2*bytes - 1).
    assign pay_last_s = {nbytes_r, 1'b0} - 12'd1;
    assign pad_last_s = {(MIN_BYTES - nbytes_r), 1'b0} - 12'd1;

    // Header byte addressed by the next nibble counter (byte = cnt/2).
    always_comb begin
        case (cnt_nxt_s[4:1])
            4'd0:    hdr_byte_s = dst_r[47:40];
            4'd1:    hdr_byte_s = dst_r[39:32];
            4'd2:    hdr_byte_s = dst_r[31:24];
            4'd3:    hdr_byte_s = dst_r[23:16];
            4'd4:    hdr_byte_s = dst_r[15:8];
            4'd5:    hdr_byte_s = dst_r[7:0];
            4'd6:    hdr_byte_s = src_r[47:40];
            4'd7:    hdr_byte_s = src_r[39:32];
            4'd8:    hdr_byte_s = src_r[31:24];
            4'd9:    hdr_byte_s = src_r[23:16];
            4'd10:   hdr_byte_s = src_r[15:8];
            4'd11:   hdr_byte_s = src_r[7:0];
            4'd12:   hdr_byte_s = type_r[15:8];
            4'd13:   hdr_byte_s = type_r[7:0];
            default: hdr_byte_s = 8'h00;
        endcase
    end

    // Complemented CRC nibble for the next FCS position, bits [3:0] first.
    always_comb begin
        case (cnt_nxt_s[2:0])
            3'd0:    fcs_nib_s = ~crc_r[3:0];
            3'd1:    fcs_nib_s = ~crc_r[7:4];
            3'd2:    fcs_nib_s = ~crc_r[11:8];
            3'd3:    fcs_nib_s = ~crc_r[15:12];
            3'd4:    fcs_nib_s = ~crc_r[19:16];
            3'd5:    fcs_nib_s = ~crc_r[23:20];
            3'd6:    fcs_nib_s = ~crc_r[27:24];
            3'd7:    fcs_nib_s = ~crc_r[31:28];
            default: fcs_nib_s = 4'h0;
        endcase
    end

    // Next-state and nibble-counter logic; a starved payload fetch aborts to the gap.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r + 12'd1;
        latch_s        = 1'b0;
        underrun_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 12'd0;
                if (start) begin
                    state_nxt_s = ST_PRE;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (cnt_r == 12'd14) begin
                    state_nxt_s = ST_SFD;
                    cnt_nxt_s   = 12'd0;
                end else begin
                    state_nxt_s = ST_PRE;
                end
            end
            ST_SFD: begin
                state_nxt_s = ST_HDR;
                cnt_nxt_s   = 12'd0;
            end
            ST_HDR: begin
                if (cnt_r == 12'd27) begin
                    cnt_nxt_s = 12'd0;
                    if (nbytes_r == 11'd0) begin
                        state_nxt_s = ST_PAD;
                    end else begin
                        state_nxt_s = ST_PAY;
                    end
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_PAY: begin
                if (cnt_r == pay_last_s) begin
                    cnt_nxt_s = 12'd0;
                    if (nbytes_r < MIN_BYTES) begin
                        state_nxt_s = ST_PAD;
                    end else begin
                        state_nxt_s = ST_FCS;
                    end
                end else begin
                    state_nxt_s = ST_PAY;
                end
            end
            ST_PAD: begin
                if (cnt_r == pad_last_s) begin
                    state_nxt_s = ST_FCS;
                    cnt_nxt_s   = 12'd0;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            ST_FCS: begin
                if (cnt_r == 12'd7) begin
                    state_nxt_s = ST_IFG;
                    cnt_nxt_s   = 12'd0;
                end else begin
                    state_nxt_s = ST_FCS;
                end
            end
            ST_IFG: begin
                if (cnt_r == IFG_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 12'd0;
                end else begin
                    state_nxt_s = ST_IFG;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 12'd0;
            end
        endcase
        if (data_ready_r && !data_valid) begin
            state_nxt_s    = ST_IFG;
            cnt_nxt_s      = 12'd0;
            underrun_nxt_s = 1'b1;
        end else begin
            underrun_nxt_s = 1'b0;
        end
    end

    // Values the registered outputs and CRC take for the upcoming nibble cycle.
    always_comb begin
        mii_dv_nxt_s   = 1'b0;
        mii_data_nxt_s = 4'h0;
        ready_nxt_s    = 1'b0;
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        done_nxt_s     = (state_nxt_s == ST_IFG) && (cnt_nxt_s == IFG_LAST);
        crc_nxt_s      = crc_r;
        case (state_nxt_s)
            ST_PRE: begin
                mii_dv_nxt_s   = 1'b1;
                mii_data_nxt_s = 4'h5;
            end
            ST_SFD: begin
                mii_dv_nxt_s   = 1'b1;
                mii_data_nxt_s = 4'hD;
            end
            ST_HDR: begin
                mii_dv_nxt_s   = 1'b1;
                mii_data_nxt_s = cnt_nxt_s[0] ? hdr_byte_s[7:4] : hdr_byte_s[3:0];
                // Payload byte 0 is fetched during the last eth_type nibble.
                ready_nxt_s    = (cnt_nxt_s == 12'd27) && (nbytes_r != 11'd0);
            end
            ST_PAY: begin
                mii_dv_nxt_s   = 1'b1;
                // Low nibble comes straight from the byte sampled this cycle.
                mii_data_nxt_s = cnt_nxt_s[0] ? byte_hi_r : data_in[3:0];
                ready_nxt_s    = cnt_nxt_s[0] &&
                                 (({1'b0, cnt_nxt_s[11:1]} + 12'd1) < {1'b0, nbytes_r});
            end
            ST_PAD: begin
                mii_dv_nxt_s   = 1'b1;
                mii_data_nxt_s = 4'h0;
            end
            ST_FCS: begin
                mii_dv_nxt_s   = 1'b1;
                mii_data_nxt_s = fcs_nib_s;
            end
            ST_IDLE: begin
                mii_dv_nxt_s   = 1'b0;
                mii_data_nxt_s = 4'h0;
            end
            ST_IFG: begin
                mii_dv_nxt_s   = 1'b0;
                mii_data_nxt_s = 4'h0;
            end
            default: begin
                mii_dv_nxt_s   = 1'b0;
                mii_data_nxt_s = 4'h0;
            end
        endcase
        if (latch_s) begin
            crc_nxt_s = CRC_INIT;
        end else if ((state_nxt_s == ST_HDR) || (state_nxt_s == ST_PAY) || (state_nxt_s == ST_PAD)) begin
            crc_nxt_s = crc32_nibble(crc_r, mii_data_nxt_s);
        end else begin
            crc_nxt_s = crc_r;
        end
    end

    // State, counters, latched frame fields, CRC and registered outputs.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 12'd0;
            dst_r        <= 48'd0;
            src_r        <= 48'd0;
            type_r       <= 16'd0;
            nbytes_r     <= 11'd0;
            byte_hi_r    <= 4'h0;
            crc_r        <= CRC_INIT;
            mii_dv_r     <= 1'b0;
            mii_data_r   <= 4'h0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            underrun_r   <= 1'b0;
            data_ready_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            crc_r        <= crc_nxt_s;
            mii_dv_r     <= mii_dv_nxt_s;
            mii_data_r   <= mii_data_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            underrun_r   <= underrun_nxt_s;
            data_ready_r <= ready_nxt_s;
            if (latch_s) begin
                dst_r    <= dst_mac;
                src_r    <= src_mac;
                type_r   <= eth_type;
                nbytes_r <= nbytes;
            end
            if (data_ready_r && data_valid) begin
                byte_hi_r <= data_in[7:4];
            end
        end
    end

endmodule

// File: tb/tb_iob_eth_mii_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_iob_eth_mii_frame_gen
//
// Directed bench for iob_eth_mii_frame_gen. Each test task drives one
// scenario, captures the MII nibble stream cycle by cycle on the falling
// edge, and compares it with a frame the bench builds itself (preamble,
// header, payload, pad and a bitwise CRC-32).
// -----------------------------------------------------------------------------
module tb_iob_eth_mii_frame_gen;

    logic        clk = 1'b0;
    logic        rst_int;
    logic        start;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [10:0] nbytes;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        mii_dv;
    logic [3:0]  mii_data;

    iob_eth_mii_frame_gen #(.IFG_NIBBLES(24), .MIN_PAYLOAD(46)) dut (
        .clk        (clk),
        .rst_int    (rst_int),
        .start      (start),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .eth_type   (eth_type),
        .nbytes     (nbytes),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .mii_dv     (mii_dv),
        .mii_data   (mii_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] pay [0:2047];
    logic [3:0] nibs[$];
    logic [3:0] exp_nib[$];

    int dv_len, ready_cnt, und_cnt, low_cnt, done_low, data_nz, dv_after_fall;
    bit done_seen, fell, und_dv_bad;
    logic first_dv, first_busy;
    logic [3:0] first_data;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic void push_byte(input logic [7:0] b, inout logic [31:0] c);
        exp_nib.push_back(b[3:0]);
        exp_nib.push_back(b[7:4]);
        c = crc_byte(c, b);
    endfunction

    // Build the expected nibble stream of a complete frame.
    function automatic void build_expected(input logic [47:0] d, input logic [47:0] s,
                                           input logic [15:0] t, input int nb);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [111:0] hdr;
        c = 32'hFFFFFFFF;
        exp_nib.delete();
        for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
        exp_nib.push_back(4'hD);
        hdr = {d, s, t};
        for (int i = 0; i < 14; i++) push_byte(hdr[111 - 8*i -: 8], c);
        for (int i = 0; i < nb; i++) push_byte(pay[i], c);
        for (int i = nb; i < 46; i++) push_byte(8'h00, c);
        fcs = ~c;
        for (int i = 0; i < 8; i++) exp_nib.push_back(fcs[4*i +: 4]);
    endfunction

    function automatic int count_mism(input int n);
        int m;
        m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= nibs.size() || i >= exp_nib.size()) m++;
            else if (nibs[i] !== exp_nib[i]) m++;
        end
        return m;
    endfunction

    // CRC register after running over everything following the SFD, FCS included.
    function automatic logic [31:0] residue();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 16; i + 1 < nibs.size(); i += 2) c = crc_byte(c, {nibs[i+1], nibs[i]});
        return c;
    endfunction

    task automatic start_frame(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t, input int nb);
        dst_mac  = d;
        src_mac  = s;
        eth_type = t;
        nbytes   = 11'(nb);
        start    = 1'b1;
        @(negedge clk);
    endtask

    // Sample one frame and its gap on falling edges, feeding payload on demand.
    // Ends on the falling edge of the cycle after done (or after a cycle budget).
    task automatic capture(input int stall_at, input int restart_at);
        int byte_idx;
        nibs.delete();
        dv_len = 0; ready_cnt = 0; und_cnt = 0; low_cnt = 0; done_low = 0;
        data_nz = 0; dv_after_fall = 0; byte_idx = 0;
        done_seen = 0; fell = 0; und_dv_bad = 0;
        first_dv = mii_dv; first_busy = busy; first_data = mii_data;
        for (int c = 0; c < 8000; c++) begin
            if (mii_dv) begin
                nibs.push_back(mii_data);
                dv_len++;
                if (fell) dv_after_fall++;
            end else begin
                fell = 1;
                low_cnt++;
                if (mii_data !== 4'h0) data_nz++;
            end
            if (underrun) begin
                und_cnt++;
                if (mii_dv !== 1'b0) und_dv_bad = 1;
            end
            start = 1'b0;
            if (c == restart_at) begin
                start   = 1'b1;
                dst_mac = 48'h111111111111;
                nbytes  = 11'd3;
            end
            data_valid = 1'b1;
            if (data_ready) begin
                ready_cnt++;
                data_in = pay[byte_idx];
                byte_idx++;
                if (ready_cnt == stall_at) data_valid = 1'b0;
            end
            if (done) begin
                done_seen = 1;
                done_low  = low_cnt;
            end
            @(negedge clk);
            if (done_seen) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_int = 1'b1; start = 1'b0; data_valid = 1'b1; data_in = 8'h00;
        dst_mac = 48'd0; src_mac = 48'd0; eth_type = 16'd0; nbytes = 11'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mii_dv, mii_data, busy, done, underrun, data_ready} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dv=%b data=%h busy=%b done=%b und=%b rdy=%b, want all 0",
                     mii_dv, mii_data, busy, done, underrun, data_ready);
        end
        rst_int = 1'b0;
    endtask

    task automatic test_frame46();
        for (int i = 0; i < 46; i++) pay[i] = 8'(i);
        build_expected(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 46);
        start_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 46);
        capture(0, -1);
        checks++;
        if ({first_dv, first_busy, first_data} !== {1'b1, 1'b1, 4'h5}) begin
            errors++;
            $display("FAIL f46_first_cycle: got dv=%b busy=%b data=%h, want 1 1 5", first_dv, first_busy, first_data);
        end
        checks++;
        if (dv_len != 144) begin errors++; $display("FAIL f46_dv_len: got %0d want 144", dv_len); end
        checks++;
        if (nibs.size() < 18 || nibs[16] !== 4'h0 || nibs[17] !== 4'h0) begin
            errors++; $display("FAIL f46_nib17_18: want 0,0 (frame size %0d)", nibs.size());
        end
        checks++;
        if (nibs.size() != exp_nib.size() || count_mism(exp_nib.size()) != 0) begin
            errors++;
            $display("FAIL f46_frame: got %0d nibbles, %0d differ, want %0d nibbles", nibs.size(),
                     count_mism(exp_nib.size()), exp_nib.size());
        end
        checks++;
        if (residue() !== 32'hDEBB20E3) begin errors++; $display("FAIL f46_residue: got %h want DEBB20E3", residue()); end
        checks++;
        if (!done_seen || done_low != 24) begin
            errors++; $display("FAIL f46_done_gap: done_seen=%0d at low cycle %0d, want 24", done_seen, done_low);
        end
        checks++;
        if (data_nz != 0 || dv_after_fall != 0 || und_cnt != 0 || ready_cnt != 46) begin
            errors++;
            $display("FAIL f46_misc: ifg_nonzero=%0d dv_regained=%0d und=%0d ready=%0d, want 0 0 0 46",
                     data_nz, dv_after_fall, und_cnt, ready_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL f46_busy_after_done: got %b want 0", busy); end
    endtask

    task automatic test_short10();
        int zeros;
        for (int i = 0; i < 10; i++) pay[i] = 8'hA0 + 8'(i);
        build_expected(48'h665544332211, 48'h0A1B2C3D4E5F, 16'h88B5, 10);
        start_frame(48'h665544332211, 48'h0A1B2C3D4E5F, 16'h88B5, 10);
        capture(0, -1);
        zeros = 0;
        for (int i = 64; i < 136 && i < nibs.size(); i++) if (nibs[i] === 4'h0) zeros++;
        checks++;
        if (ready_cnt != 10) begin errors++; $display("FAIL s10_ready_pulses: got %0d want 10", ready_cnt); end
        checks++;
        if (dv_len != 144) begin errors++; $display("FAIL s10_dv_len: got %0d want 144", dv_len); end
        checks++;
        if (zeros != 72) begin errors++; $display("FAIL s10_pad_zero_nibbles: got %0d want 72", zeros); end
        checks++;
        if (nibs.size() != exp_nib.size() || count_mism(exp_nib.size()) != 0 || residue() !== 32'hDEBB20E3) begin
            errors++;
            $display("FAIL s10_frame_fcs: %0d differ, residue %h, want 0 and DEBB20E3",
                     count_mism(exp_nib.size()), residue());
        end
    endtask

    task automatic test_zero();
        build_expected(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 0);
        start_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 0);
        capture(0, -1);
        checks++;
        if (ready_cnt != 0 || dv_len != 144) begin
            errors++; $display("FAIL z0_len: ready=%0d dv_len=%0d, want 0 and 144", ready_cnt, dv_len);
        end
        checks++;
        if (nibs.size() != exp_nib.size() || count_mism(exp_nib.size()) != 0) begin
            errors++; $display("FAIL z0_frame: %0d nibbles differ, want 0", count_mism(exp_nib.size()));
        end
    endtask

    task automatic test_long1500();
        for (int i = 0; i < 1500; i++) pay[i] = 8'(i * 7 + 3);
        build_expected(48'h123456789ABC, 48'hDEF012345678, 16'h86DD, 1500);
        start_frame(48'h123456789ABC, 48'hDEF012345678, 16'h86DD, 1500);
        capture(0, -1);
        checks++;
        if (dv_len != 3052 || und_cnt != 0) begin
            errors++; $display("FAIL l1500_len: dv_len=%0d und=%0d, want 3052 and 0", dv_len, und_cnt);
        end
        checks++;
        if (nibs.size() != exp_nib.size() || count_mism(exp_nib.size()) != 0 || residue() !== 32'hDEBB20E3) begin
            errors++;
            $display("FAIL l1500_frame_fcs: %0d differ, residue %h, want 0 and DEBB20E3",
                     count_mism(exp_nib.size()), residue());
        end
    endtask

    // Starts in the busy=0 cycle straight after the previous done.
    task automatic test_back_to_back();
        for (int i = 0; i < 46; i++) pay[i] = 8'hFF - 8'(i);
        build_expected(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 46);
        start_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 46);
        capture(0, -1);
        checks++;
        if (first_dv !== 1'b1 || dv_len != 144) begin
            errors++; $display("FAIL b2b_accept: first dv=%b dv_len=%0d, want 1 and 144", first_dv, dv_len);
        end
        checks++;
        if (count_mism(exp_nib.size()) != 0) begin
            errors++; $display("FAIL b2b_frame: %0d nibbles differ, want 0", count_mism(exp_nib.size()));
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 46; i++) pay[i] = 8'h30 + 8'(i);
        build_expected(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 46);
        start_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 46);
        capture(5, -1);
        checks++;
        if (und_cnt != 1 || und_dv_bad) begin
            errors++; $display("FAIL und_pulse: pulses=%0d dv_high_in_pulse=%0d, want 1 and 0", und_cnt, und_dv_bad);
        end
        checks++;
        if (dv_len != 52 || nibs.size() != 52 || count_mism(52) != 0) begin
            errors++; $display("FAIL und_truncate: dv_len=%0d, %0d differ, want 52 and 0", dv_len, count_mism(52));
        end
        checks++;
        if (!done_seen || done_low != 24 || busy !== 1'b0) begin
            errors++; $display("FAIL und_done: done at low cycle %0d busy=%b, want 24 and 0", done_low, busy);
        end
    endtask

    task automatic test_busy_ignore();
        bit quiet;
        for (int i = 0; i < 20; i++) pay[i] = 8'h5A ^ 8'(i);
        build_expected(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0800, 20);
        start_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0800, 20);
        capture(0, 20);
        checks++;
        if (dv_len != 144 || count_mism(exp_nib.size()) != 0) begin
            errors++;
            $display("FAIL busy_ignore_frame: dv_len=%0d, %0d differ, want 144 and 0", dv_len, count_mism(exp_nib.size()));
        end
        quiet = 1;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || mii_dv !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL busy_ignore_no_queue: got a queued frame, want idle"); end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 46; i++) pay[i] = 8'(i);
        start_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 46);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst_int = 1'b1;
        #1;
        checks++;
        if ({mii_dv, mii_data, busy, done, underrun, data_ready} !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got dv=%b data=%h busy=%b done=%b und=%b rdy=%b, want all 0",
                     mii_dv, mii_data, busy, done, underrun, data_ready);
        end
        @(negedge clk);
        rst_int = 1'b0;
        build_expected(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 46);
        start_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 46);
        capture(0, -1);
        checks++;
        if (first_dv !== 1'b1 || dv_len != 144 || count_mism(exp_nib.size()) != 0) begin
            errors++;
            $display("FAIL rst_mid_restart: first dv=%b dv_len=%0d, %0d differ, want 1, 144, 0",
                     first_dv, dv_len, count_mism(exp_nib.size()));
        end
    endtask

    initial begin
        test_reset();
        test_frame46();
        test_short10();
        test_zero();
        test_long1500();
        test_back_to_back();
        test_underrun();
        test_busy_ignore();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
